// File: rtl/adc_serial_if_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : adc_serial_if_if                                       |
// | Description : Signal bundle between the ADC serial front end and its |
// |               neighbours: ADC pins (SDO/DIN/cs_n), the config word   |
// |               feeding the serializer, and the parallel sample output.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface adc_serial_if_if #(
    parameter int DATA_W = 12,
    parameter int CFG_W  = 8
);
    logic              SDO;
    logic [CFG_W-1:0]  data;
    logic              DIN;
    logic              cs_n;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic [3:0]        bit_idx;

    // The serial front end
    modport master (
        input  SDO,
        input  data,
        output DIN,
        output cs_n,
        output sample,
        output sample_valid,
        output bit_idx
    );

    // ADC pins plus the sample consumer / config source
    modport slave (
        output SDO,
        output data,
        input  DIN,
        input  cs_n,
        input  sample,
        input  sample_valid,
        input  bit_idx
    );
endinterface
`default_nettype wire

// File: rtl/adc_serial_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : adc_serial_if                                          |
// | Description : Free-running SPI-style ADC front end. Captures an      |
// |               LSB-first sample on SDO while shifting a config word   |
// |               MSB-first onto DIN, one bit per clk.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module adc_serial_if #(
    parameter int DATA_W       = 12,
    parameter int CFG_W        = 8,
    parameter int QUIET_CYCLES = 0
) (
    input wire              clk,
    input wire              rst_n,
    adc_serial_if_if.master adc
);
    localparam logic [3:0]      c_LAST_IDX   = 4'(DATA_W - 1);
    localparam int              c_QW         = $clog2(QUIET_CYCLES + 2);
    localparam logic [c_QW-1:0] c_QUIET_LAST = c_QW'(QUIET_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_SHIFT = 2'd1,
        ST_QUIET = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic              w_shift;
    logic              w_last;

    logic              r_cs_n;
    logic              r_din;
    logic [CFG_W-1:0]  r_cfg;
    // Only DATA_W-1 bits are kept: the final bit goes straight from SDO into sample.
    logic [DATA_W-2:0] r_cap;
    logic [DATA_W-1:0] r_sample;
    logic              r_valid;
    logic [3:0]        r_bit_idx;
    logic [c_QW-1:0]   r_quiet_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus load/shift/last strobes for the datapath
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_START: begin
                w_load      = 1'b1;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_bit_idx == c_LAST_IDX) begin
                    w_last = 1'b1;
                    if (QUIET_CYCLES > 0) begin
                        w_state_nxt = ST_QUIET;
                    end else begin
                        // Back-to-back: the next frame starts on the very next edge
                        w_load = 1'b1;
                    end
                end
            end
            ST_QUIET: begin
                if (r_quiet_cnt == c_QUIET_LAST) begin
                    w_state_nxt = ST_START;
                end
            end
            default: begin
                w_state_nxt = ST_START;
            end
        endcase
    end

    // Chip select is high exactly while the quiet window runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n <= 1'b1;
        end else begin
            r_cs_n <= (w_state_nxt == ST_QUIET);
        end
    end

    // SDO deserializer, bit counter and sample/valid publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap     <= '0;
            r_bit_idx <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_last;
            if (w_shift) begin
                r_cap     <= {adc.SDO, r_cap[DATA_W-2:1]};
                r_bit_idx <= w_last ? 4'd0 : r_bit_idx + 4'd1;
            end
            if (w_last) begin
                r_sample <= {adc.SDO, r_cap};
            end
        end
    end

    // Config serializer: MSB first, zeros once the word is exhausted or between frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din <= 1'b0;
            r_cfg <= '0;
        end else if (w_load) begin
            r_din <= adc.data[CFG_W-1];
            r_cfg <= {adc.data[CFG_W-2:0], 1'b0};
        end else if (w_shift && !w_last) begin
            r_din <= r_cfg[CFG_W-1];
            r_cfg <= {r_cfg[CFG_W-2:0], 1'b0};
        end else begin
            r_din <= 1'b0;
        end
    end

    // Quiet-window length counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quiet_cnt <= '0;
        end else if (r_state == ST_QUIET) begin
            r_quiet_cnt <= r_quiet_cnt + c_QW'(1);
        end else begin
            r_quiet_cnt <= '0;
        end
    end

    assign adc.DIN          = r_din;
    assign adc.cs_n         = r_cs_n;
    assign adc.sample       = r_sample;
    assign adc.sample_valid = r_valid;
    assign adc.bit_idx      = r_bit_idx;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_adc_serial_if                                       |
// | Description : Self-checking bench for adc_serial_if. Two instances   |
// |               (back-to-back and QUIET_CYCLES=3) run against a frame- |
// |               timeline reference model.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_adc_serial_if;
    localparam int DW = 12;
    localparam int CW = 8;
    localparam int QB = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_serial_if_if #(.DATA_W(DW), .CFG_W(CW)) bus_a ();
    adc_serial_if_if #(.DATA_W(DW), .CFG_W(CW)) bus_b ();

    adc_serial_if #(.DATA_W(DW), .CFG_W(CW), .QUIET_CYCLES(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .adc   (bus_a.master)
    );

    adc_serial_if #(.DATA_W(DW), .CFG_W(CW), .QUIET_CYCLES(QB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .adc   (bus_b.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // SDO source per instance: 0 random, 1 pattern, 2 all zero, 3 all one
    int            sdo_mode [2];
    logic [DW-1:0] pat_reg = 12'hF9F;

    // ---------------- reference model (frame timeline) ----------------
    // Cycle 0 is the START cycle after reset release. Back-to-back:
    // cycle c>=1 is frame bit (c-1)%DW. With a quiet window the timeline
    // repeats every DW+Q+1 cycles: START, DW bits, Q quiet cycles.
    int            m_cyc    [2];
    logic [DW-1:0] m_acc    [2];
    logic [DW-1:0] m_sample [2];
    logic          m_valid  [2];
    logic [CW-1:0] m_fdata  [2];

    function automatic int kind_of(input int d, input int c); // 0 start, 1 shift, 2 quiet
        int q;
        int p;
        q = (d == 0) ? 0 : QB;
        if (q == 0) return (c == 0) ? 0 : 1;
        p = c % (DW + q + 1);
        if (p == 0) return 0;
        if (p <= DW) return 1;
        return 2;
    endfunction

    function automatic int bit_of(input int d, input int c);
        if (d == 0) return (c - 1) % DW;
        return (c % (DW + QB + 1)) - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_cyc[d]    <= 0;
                m_acc[d]    <= '0;
                m_sample[d] <= '0;
                m_valid[d]  <= 1'b0;
                m_fdata[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_valid[d] <= (kind_of(d, m_cyc[d]) == 1) && (bit_of(d, m_cyc[d]) == DW - 1);
                if (kind_of(d, m_cyc[d]) == 1)
                    m_acc[d][bit_of(d, m_cyc[d])] <= (d == 0) ? bus_a.SDO : bus_b.SDO;
                if ((kind_of(d, m_cyc[d]) == 1) && (bit_of(d, m_cyc[d]) == DW - 1))
                    m_sample[d] <= {((d == 0) ? bus_a.SDO : bus_b.SDO), m_acc[d][DW-2:0]};
                if ((kind_of(d, m_cyc[d] + 1) == 1) && (bit_of(d, m_cyc[d] + 1) == 0))
                    m_fdata[d] <= (d == 0) ? bus_a.data : bus_b.data;
                m_cyc[d] <= m_cyc[d] + 1;
            end
        end
    end

    // Expected {cs_n, DIN, sample_valid, bit_idx, sample} for the current cycle
    function automatic logic [18:0] model_vec(input int d);
        int         c;
        int         k;
        logic       cs;
        logic       din;
        logic [3:0] idx;
        c   = m_cyc[d];
        k   = bit_of(d, c);
        cs  = 1'b1;
        din = 1'b0;
        idx = 4'd0;
        if (kind_of(d, c) == 1) begin
            cs  = 1'b0;
            idx = 4'(k);
            if (k < CW) din = m_fdata[d][CW-1-k];
        end else if (kind_of(d, c) == 0 && c != 0) begin
            cs = 1'b0;
        end
        return {cs, din, m_valid[d], idx, m_sample[d]};
    endfunction

    function automatic logic [18:0] dut_vec(input int d);
        if (d == 0)
            return {bus_a.cs_n, bus_a.DIN, bus_a.sample_valid, bus_a.bit_idx, bus_a.sample};
        return {bus_b.cs_n, bus_b.DIN, bus_b.sample_valid, bus_b.bit_idx, bus_b.sample};
    endfunction

    function automatic logic next_sdo(input int d);
        int c;
        c = m_cyc[d];
        if (kind_of(d, c) == 1) begin
            case (sdo_mode[d])
                1:       return pat_reg[bit_of(d, c)];
                2:       return 1'b0;
                3:       return 1'b1;
                default: return 1'($urandom);
            endcase
        end
        return 1'($urandom);
    endfunction

    // SDO driver: new bit shortly after every rising edge
    initial begin
        bus_a.SDO = 1'b0;
        bus_b.SDO = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus_a.SDO = next_sdo(0);
            bus_b.SDO = next_sdo(1);
        end
    end

    // ---------------------------- tests ----------------------------
    task automatic test_reset();
        logic [4:0] exp;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (dut_vec(d) !== {1'b1, 1'b0, 1'b0, 4'd0, 12'd0}) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: got %h expected %h", d, dut_vec(d), 19'h40000);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int c = 0; c <= DW; c++) begin
            if (c > 0) @(negedge clk);
            exp = (c == 0) ? {1'b1, 4'd0} : {1'b0, 4'(c - 1)};
            n_checks++;
            if ({bus_a.cs_n, bus_a.bit_idx} !== exp || {bus_b.cs_n, bus_b.bit_idx} !== exp) begin
                n_fail++;
                $display("FAIL start_seq cycle %0d: a=%h b=%h expected %h", c,
                         {bus_a.cs_n, bus_a.bit_idx}, {bus_b.cs_n, bus_b.bit_idx}, exp);
            end
        end
    endtask

    task automatic test_pattern();
        int pa = 0;
        int pb = 0;
        int guard = 0;
        sdo_mode[0] = 1;
        sdo_mode[1] = 1;
        while ((pa < 4 || pb < 3) && guard < 120) begin
            @(negedge clk);
            guard++;
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (dut_vec(d) !== model_vec(d)) begin
                    n_fail++;
                    $display("FAIL pattern_model dut%0d: got %h expected %h", d, dut_vec(d), model_vec(d));
                end
            end
            if (m_valid[0]) begin
                pa++;
                if (pa > 1) begin
                    n_checks++;
                    if ({bus_a.sample_valid, bus_a.sample} !== {1'b1, 12'hF9F}) begin
                        n_fail++;
                        $display("FAIL pattern_a: got %h expected %h", {bus_a.sample_valid, bus_a.sample}, 13'h1F9F);
                    end
                end
            end
            if (m_valid[1]) begin
                pb++;
                if (pb > 1) begin
                    n_checks++;
                    if ({bus_b.sample_valid, bus_b.sample} !== {1'b1, 12'hF9F}) begin
                        n_fail++;
                        $display("FAIL pattern_b: got %h expected %h", {bus_b.sample_valid, bus_b.sample}, 13'h1F9F);
                    end
                end
            end
        end
        n_checks++;
        if (guard >= 120) begin
            n_fail++;
            $display("FAIL pattern_timeout: got %0d/%0d pulses expected 4/3", pa, pb);
        end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int gaps = 0;
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.cs_n !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_cs_n cycle %0d: got %b expected 0", j, bus_a.cs_n);
            end
            if (bus_a.sample_valid === 1'b1) begin
                if (last >= 0) begin
                    gaps++;
                    n_checks++;
                    if (j - last != 12) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d expected 12", j - last);
                    end
                end
                last = j;
            end
        end
        n_checks++;
        if (gaps < 3) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d gaps expected 3", gaps);
        end
    endtask

    task automatic test_din();
        logic [7:0] d1 = 8'b10011001;
        logic [7:0] d2 = 8'hA5;
        logic [7:0] w;
        logic       exp;
        int         k;
        int         guard = 0;
        while (!(kind_of(0, m_cyc[0]) == 1 && bit_of(0, m_cyc[0]) == 0) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        bus_a.data = d1;
        repeat (DW) @(negedge clk);
        for (int j = 0; j < 2 * DW; j++) begin
            if (j > 0) @(negedge clk);
            k   = j % DW;
            w   = (j < DW) ? d1 : d2;
            exp = (k < CW) ? w[CW-1-k] : 1'b0;
            n_checks++;
            if (bus_a.DIN !== exp) begin
                n_fail++;
                $display("FAIL din frame %0d bit %0d: got %b expected %b", j / DW, k, bus_a.DIN, exp);
            end
            if (j == 5) bus_a.data = d2;
        end
    endtask

    task automatic test_quiet();
        int   run = 0;
        bit   armed = 1'b0;
        int   last = -1;
        int   gaps = 0;
        int   runs = 0;
        sdo_mode[0] = 0;
        sdo_mode[1] = 0;
        for (int j = 0; j < 90 && gaps < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec(1) !== model_vec(1)) begin
                n_fail++;
                $display("FAIL quiet_model: got %h expected %h", dut_vec(1), model_vec(1));
            end
            if (bus_b.cs_n === 1'b1) begin
                run++;
            end else begin
                if (armed && run > 0) begin
                    runs++;
                    n_checks++;
                    if (run != QB) begin
                        n_fail++;
                        $display("FAIL quiet_cs_high: got %0d expected %0d", run, QB);
                    end
                end
                armed = 1'b1;
                run   = 0;
            end
            if (bus_b.sample_valid === 1'b1) begin
                if (last >= 0) begin
                    gaps++;
                    n_checks++;
                    if (j - last != 16) begin
                        n_fail++;
                        $display("FAIL quiet_spacing: got %0d expected 16", j - last);
                    end
                end
                last = j;
            end
        end
        n_checks++;
        if (gaps < 3 || runs < 2) begin
            n_fail++;
            $display("FAIL quiet_timeout: got %0d gaps %0d runs expected 3 and 2", gaps, runs);
        end
    endtask

    task automatic test_zero_ones();
        int            guard = 0;
        int            np = 0;
        logic [DW-1:0] s [2];
        s[0] = '1;
        s[1] = '0;
        while (!(kind_of(0, m_cyc[0]) == 1 && bit_of(0, m_cyc[0]) == DW - 1) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        sdo_mode[0] = 2;
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            if (j == 12) sdo_mode[0] = 3;
            if (j == 24) sdo_mode[0] = 0;
            if (j >= 2 && bus_a.sample_valid === 1'b1) begin
                if (np < 2) s[np] = bus_a.sample;
                np++;
            end
        end
        n_checks++;
        if (np != 2) begin
            n_fail++;
            $display("FAIL zero_ones_pulses: got %0d expected 2", np);
        end
        n_checks++;
        if (s[0] !== 12'h000 || s[1] !== 12'hFFF) begin
            n_fail++;
            $display("FAIL zero_ones_samples: got %h,%h expected 000,fff", s[0], s[1]);
        end
    endtask

    task automatic test_random();
        sdo_mode[0] = 0;
        sdo_mode[1] = 0;
        for (int j = 0; j < 120; j++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (dut_vec(d) !== model_vec(d)) begin
                    n_fail++;
                    $display("FAIL random_model dut%0d cycle %0d: got %h expected %h", d, j, dut_vec(d), model_vec(d));
                end
            end
            if ($urandom_range(7, 0) == 0) bus_a.data = 8'($urandom);
            if ($urandom_range(7, 0) == 0) bus_b.data = 8'($urandom);
        end
    endtask

    task automatic test_reset_midframe();
        int guard = 0;
        while (!(kind_of(0, m_cyc[0]) == 1 && bit_of(0, m_cyc[0]) == 5) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (dut_vec(d) !== {1'b1, 1'b0, 1'b0, 4'd0, 12'd0}) begin
                n_fail++;
                $display("FAIL midframe_reset dut%0d: got %h expected %h", d, dut_vec(d), 19'h40000);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int j = 0; j < 30; j++) begin
            if (j > 0) @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (dut_vec(d) !== model_vec(d)) begin
                    n_fail++;
                    $display("FAIL post_reset_model dut%0d cycle %0d: got %h expected %h", d, j, dut_vec(d), model_vec(d));
                end
            end
            if (j <= DW) begin
                n_checks++;
                if ({bus_a.sample_valid, bus_a.sample} !== 13'd0) begin
                    n_fail++;
                    $display("FAIL post_reset_sample cycle %0d: got %h expected 0", j, {bus_a.sample_valid, bus_a.sample});
                end
            end
        end
    endtask

    initial begin
        sdo_mode[0] = 0;
        sdo_mode[1] = 0;
        bus_a.data  = 8'h00;
        bus_b.data  = 8'h3C;
        test_reset();
        test_pattern();
        test_back_to_back();
        test_din();
        test_quiet();
        test_zero_ones();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
